p2s_ctrl: RTL

Sequencer for the 8:1 parallel-to-serial bit mux. Accepts bytes over a valid/ready handshake and holds each accepted byte stable on the mux data inputs. Steps the 3-bit mux select once per clock and flags which cycles carry a valid serial bit. Supports back-to-back bytes with no idle bit between them, plus a stall input that freezes the serializer.

---
 rtl/p2s_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/p2s_ctrl.sv
// p2s_ctrl: sequencer for an 8:1 parallel-to-serial bit mux.
// Holds each accepted byte on the mux data inputs and steps the 3-bit select
// once per enabled clock. Back-to-back bytes follow with no gap bit, and tx_en
// stalls the serializer.
module p2s_ctrl #(
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             tx_en,
  output logic [7:0]       data_hold,
  output logic [2:0]       sel,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt
);

  // Select walks from SEL_FIRST to SEL_LAST. Adding 3'd7 modulo 8 is the same as subtracting 1.
  localparam logic [2:0] SEL_FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] SEL_LAST  = MSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [2:0] SEL_STEP  = MSB_FIRST ? 3'd7 : 3'd1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t state_r;
  logic   ready_s;
  logic   accept_s;
  logic   last_s;

  assign last_s = (sel == SEL_LAST);

  // Ready depends only on state, tx_en and select, and never on valid_in.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE:  ready_s = 1'b1;
      ST_SHIFT: ready_s = tx_en & last_s;
      default:  ready_s = 1'b0;
    endcase
  end

  assign ready_out = ready_s;
  assign accept_s  = valid_in & ready_s;
  assign busy      = (state_r == ST_SHIFT);

  // Serializer state: loads the byte, steps the select, and produces the bit flags and the byte counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      data_hold   <= 8'h00;
      sel         <= SEL_FIRST;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      byte_cnt    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_SHIFT;
            data_hold   <= data_in;
            sel         <= SEL_FIRST;
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!tx_en) begin
            // Stall: hold the byte and the select. frame_start is held so it
            // stays high while the first bit waits.
            bit_valid <= 1'b0;
          end else if (!last_s) begin
            sel         <= sel + SEL_STEP;
            bit_valid   <= 1'b1;
            frame_start <= 1'b0;
          end else begin
            byte_cnt <= byte_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (accept_s) begin
              data_hold   <= data_in;
              sel         <= SEL_FIRST;
              bit_valid   <= 1'b1;
              frame_start <= 1'b1;
            end else begin
              state_r     <= ST_IDLE;
              sel         <= SEL_FIRST;
              bit_valid   <= 1'b0;
              frame_start <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          sel         <= SEL_FIRST;
          bit_valid   <= 1'b0;
          frame_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
